// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared types and constants for the conv2d inference sequencer: the
// sequencer state encoding, image/kernel/output geometry, index widths,
// and a tap-number to (dx, dy) offset helper used by the window address
// generator.
package cnn_pkg;

    localparam int IMG_W    = 8;
    localparam int OUT_W    = 6;
    localparam int KSIZE    = 3;
    localparam int NUM_POS  = OUT_W * OUT_W;   // 36
    localparam int NUM_TAPS = KSIZE * KSIZE;   // 9
    localparam int NUM_PIX  = IMG_W * IMG_W;   // 64

    localparam int ADDR_W   = 6;   // image buffer address
    localparam int TAP_W    = 4;   // kernel tap index 0..8
    localparam int POS_W    = 6;   // output position 0..35
    localparam int COORD_W  = 3;   // output x / y coordinate 0..5
    localparam int RES_W    = 6;   // returned result count 0..36

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_CONV,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Kernel tap -> {dy, dx}; a lookup keeps the mod/div by 3 out of hardware.
    function automatic logic [3:0] tap_offset(input logic [TAP_W-1:0] tap);
        logic [3:0] r;
        case (tap)
            4'd0:    r = {2'd0, 2'd0};
            4'd1:    r = {2'd0, 2'd1};
            4'd2:    r = {2'd0, 2'd2};
            4'd3:    r = {2'd1, 2'd0};
            4'd4:    r = {2'd1, 2'd1};
            4'd5:    r = {2'd1, 2'd2};
            4'd6:    r = {2'd2, 2'd0};
            4'd7:    r = {2'd2, 2'd1};
            4'd8:    r = {2'd2, 2'd2};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cnn_seq_ctrl_window_addr_gen.sv
// window_addr_gen
// Purely combinational window address generator. Maps an output position
// (cx, cy) and kernel tap to the image buffer read address of that tap,
// flagging taps that fall outside the image (same-padding border).
// Ports:
//   cx, cy    in  output position coordinates (0..5)
//   tap_idx   in  kernel tap 0..8
//   tap_addr  out image buffer address (0 when padded)
//   tap_pad   out tap lies outside the 8x8 image
module window_addr_gen
    import cnn_pkg::*;
(
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    input  logic [TAP_W-1:0]   tap_idx,
    output logic [ADDR_W-1:0]  tap_addr,
    output logic               tap_pad
);

    logic [1:0]                dx;
    logic [1:0]                dy;
    logic signed [COORD_W+1:0] px;
    logic signed [COORD_W+1:0] py;

    localparam logic signed [COORD_W+1:0] EDGE_MAX = (COORD_W+2)'(IMG_W - 1);

    always_comb begin
        {dy, dx} = tap_offset(tap_idx);
        px = $signed({2'b00, cx}) + $signed({3'b000, dx}) - 5'sd1;
        py = $signed({2'b00, cy}) + $signed({3'b000, dy}) - 5'sd1;
        tap_pad = (px < 5'sd0) || (px > EDGE_MAX) ||
                  (py < 5'sd0) || (py > EDGE_MAX);
        // IMG_W is 8, so py*8+px is a plain bit concatenation.
        tap_addr = tap_pad ? '0 : {py[2:0], px[2:0]};
    end

endmodule

// File: rtl/cnn_seq_ctrl.sv
// cnn_seq_ctrl
// Sequencer for the conv2d inference datapath. LOAD accepts 64 pixels over
// pix_valid/pix_ready and strobes them into the image buffer; CONV walks 36
// output positions x 9 taps driving tap address/pad, accumulate and commit
// controls; DRAIN counts results returning from the post-processing pipe;
// DONE holds until restart.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ena                   global enable; low freezes counters and state
//   pix_valid/pix_ready   pixel handshake
//   buf_we/buf_waddr      image buffer write strobe / address
//   tap_addr/tap_pad      buffer read address for current tap / zero-pad
//   tap_idx/pos_idx       current kernel tap / output position
//   acc_clr/acc_en/commit MAC controls
//   pipe_valid            result leaving the last pipeline stage
//   restart               DONE -> LOAD pulse
//   busy/done/err         status (err sticky until reset or restart)
module cnn_seq_ctrl
    import cnn_pkg::*;
#(
    parameter int IMG_W     = 8,
    parameter int OUT_W     = 6,
    parameter int KSIZE     = 3,
    parameter int DRAIN_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              tap_pad,
    output logic [TAP_W-1:0]  tap_idx,
    output logic [POS_W-1:0]  pos_idx,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              commit,
    input  logic              pipe_valid,
    input  logic              restart,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDLE_W = $clog2(DRAIN_MAX + 1);

    localparam logic [ADDR_W-1:0]  LAST_PIX  = ADDR_W'(IMG_W * IMG_W - 1);
    localparam logic [TAP_W-1:0]   LAST_TAP  = TAP_W'(KSIZE * KSIZE - 1);
    localparam logic [POS_W-1:0]   LAST_POS  = POS_W'(OUT_W * OUT_W - 1);
    localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(OUT_W - 1);
    localparam logic [RES_W-1:0]   RES_FULL  = RES_W'(OUT_W * OUT_W);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(DRAIN_MAX - 1);

    state_t              state;
    logic [ADDR_W-1:0]   pix_cnt;
    logic [TAP_W-1:0]    tap;
    logic [POS_W-1:0]    pos;
    logic [COORD_W-1:0]  cx;
    logic [COORD_W-1:0]  cy;
    logic [RES_W-1:0]    res_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                err_q;

    logic                xfer;
    logic [ADDR_W-1:0]   gen_addr;
    logic                gen_pad;

    window_addr_gen u_wag (
        .cx       (cx),
        .cy       (cy),
        .tap_idx  (tap),
        .tap_addr (gen_addr),
        .tap_pad  (gen_pad)
    );

    // rst_n gates pix_ready so nothing is offered while reset is held.
    always_comb begin
        pix_ready = rst_n && ena && (state == ST_LOAD);
        xfer      = pix_valid && pix_ready;
        buf_we    = xfer;
        buf_waddr = pix_cnt;
        acc_en    = ena && (state == ST_CONV);
        acc_clr   = acc_en && (tap == '0);
        commit    = acc_en && (tap == LAST_TAP);
        tap_idx   = tap;
        pos_idx   = pos;
        tap_addr  = (state == ST_CONV) ? gen_addr : '0;
        tap_pad   = (state == ST_CONV) && gen_pad;
        busy      = (state == ST_CONV) || (state == ST_DRAIN);
        done      = (state == ST_DONE);
        err       = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_LOAD;
            pix_cnt  <= '0;
            tap      <= '0;
            pos      <= '0;
            cx       <= '0;
            cy       <= '0;
            res_cnt  <= '0;
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            // Results are counted outside LOAD regardless of ena; a pulse
            // beyond the full count is an overcount error.
            if ((state != ST_LOAD) && pipe_valid) begin
                if (res_cnt == RES_FULL) begin
                    err_q <= 1'b1;
                end else begin
                    res_cnt <= res_cnt + 1'b1;
                end
            end

            case (state)
                ST_LOAD: begin
                    if (xfer) begin
                        if (pix_cnt == LAST_PIX) begin
                            pix_cnt <= '0;
                            state   <= ST_CONV;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end

                ST_CONV: begin
                    if (ena) begin
                        if (tap == LAST_TAP) begin
                            tap <= '0;
                            if (pos == LAST_POS) begin
                                pos      <= '0;
                                cx       <= '0;
                                cy       <= '0;
                                idle_cnt <= '0;
                                state    <= ST_DRAIN;
                            end else begin
                                pos <= pos + 1'b1;
                                if (cx == LAST_X) begin
                                    cx <= '0;
                                    cy <= cy + 1'b1;
                                end else begin
                                    cx <= cx + 1'b1;
                                end
                            end
                        end else begin
                            tap <= tap + 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (ena) begin
                        if (res_cnt == RES_FULL) begin
                            state <= ST_DONE;
                        end else if (pipe_valid) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    // Overrides the result-count update above.
                    if (restart) begin
                        state    <= ST_LOAD;
                        pix_cnt  <= '0;
                        tap      <= '0;
                        pos      <= '0;
                        cx       <= '0;
                        cy       <= '0;
                        res_cnt  <= '0;
                        idle_cnt <= '0;
                        err_q    <= 1'b0;
                    end
                end

                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// tb_cnn_seq_ctrl
// Self-checking bench for cnn_seq_ctrl: pixel load, full CONV walk with a
// stall, drain completion, drain timeout, overcount, restart and mid-run reset.
module tb_cnn_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       pix_valid;
    logic       pix_ready;
    logic       buf_we;
    logic [5:0] buf_waddr;
    logic [5:0] tap_addr;
    logic       tap_pad;
    logic [3:0] tap_idx;
    logic [5:0] pos_idx;
    logic       acc_clr;
    logic       acc_en;
    logic       commit;
    logic       pipe_valid;
    logic       restart;
    logic       busy;
    logic       done;
    logic       err;

    cnn_seq_ctrl #(
        .IMG_W     (8),
        .OUT_W     (6),
        .KSIZE     (3),
        .DRAIN_MAX (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .buf_we     (buf_we),
        .buf_waddr  (buf_waddr),
        .tap_addr   (tap_addr),
        .tap_pad    (tap_pad),
        .tap_idx    (tap_idx),
        .pos_idx    (pos_idx),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .commit     (commit),
        .pipe_valid (pipe_valid),
        .restart    (restart),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference geometry: returns pad*64 + addr.
    function automatic int geo(input int pos, input int tap);
        int cx, cy, px, py;
        cx = pos % 6;
        cy = pos / 6;
        px = cx + (tap % 3) - 1;
        py = cy + (tap / 3) - 1;
        if (px < 0 || px > 7 || py < 0 || py > 7) return 64;
        return py * 8 + px;
    endfunction

    typedef struct {
        int pos;
        int tap;
    } step_t;

    typedef struct {
        int pos;
        int tap;
        int exp_addr;
        int exp_pad;
    } geo_vec_t;

    step_t    conv_q[$];
    int       load_q[$];
    geo_vec_t geo_tab[8];

    int obs_addr[36][9];
    int obs_pad[36][9];

    bit mon_en = 1'b0;
    int conv_cycles = 0;
    int commits = 0;

    // CONV monitor: pops the expected (pos, tap) for every enabled cycle.
    always @(negedge clk) begin
        if (mon_en && acc_en) begin
            conv_cycles++;
            if (conv_q.size() == 0) begin
                chk("conv_extra_cycle", 1, 0);
            end else begin
                step_t e;
                int g;
                e = conv_q.pop_front();
                g = geo(e.pos, e.tap);
                chk("pos_idx", int'(pos_idx), e.pos);
                chk("tap_idx", int'(tap_idx), e.tap);
                chk("acc_clr", int'(acc_clr), int'(e.tap == 0));
                chk("commit", int'(commit), int'(e.tap == 8));
                chk("tap_addr", int'(tap_addr), g % 64);
                chk("tap_pad", int'(tap_pad), g / 64);
                obs_addr[e.pos][e.tap] = int'(tap_addr);
                obs_pad[e.pos][e.tap]  = int'(tap_pad);
            end
            if (commit) commits++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_conv_q();
        conv_q.delete();
        for (int p = 0; p < 36; p++)
            for (int t = 0; t < 9; t++) begin
                step_t s;
                s.pos = p;
                s.tap = t;
                conv_q.push_back(s);
            end
        conv_cycles = 0;
        commits = 0;
    endtask

    task automatic load_image();
        pix_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            load_q.push_back(i);
            sample();
            chk("load_pix_ready", int'(pix_ready), 1);
            chk("load_buf_we", int'(buf_we), 1);
            if (buf_we && load_q.size() > 0)
                chk("buf_waddr", int'(buf_waddr), load_q.pop_front());
            tick();
        end
        pix_valid = 1'b0;
        load_q.delete();
        sample();
        chk("post_load_pix_ready", int'(pix_ready), 0);
        chk("post_load_busy", int'(busy), 1);
        tick();
    endtask

    task automatic wait_conv_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            sample();
            tick();
            if (commits == 36) begin
                seen = 1'b1;
                break;
            end
        end
        chk("conv_finish_timeout", int'(seen), 1);
        chk("conv_cycles", conv_cycles, 324);
        chk("commit_count", commits, 36);
        chk("conv_q_left", conv_q.size(), 0);
        sample();
        chk("drain_busy", int'(busy), 1);
        chk("drain_acc_en", int'(acc_en), 0);
        chk("drain_done", int'(done), 0);
        tick();
    endtask

    task automatic send_results(input int n);
        for (int k = 0; k < n; k++) begin
            pipe_valid = 1'b1;
            tick();
            pipe_valid = 1'b0;
            tick();
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        sample();
        chk("restart_pix_ready", int'(pix_ready), 1);
        chk("restart_err", int'(err), 0);
        chk("restart_done", int'(done), 0);
        chk("restart_busy", int'(busy), 0);
        chk("restart_waddr", int'(buf_waddr), 0);
        tick();
    endtask

    initial begin
        bit found;
        int idle_n;

        geo_tab[0] = '{pos: 0,  tap: 0, exp_addr: 0,  exp_pad: 1};
        geo_tab[1] = '{pos: 0,  tap: 4, exp_addr: 0,  exp_pad: 0};
        geo_tab[2] = '{pos: 7,  tap: 8, exp_addr: 18, exp_pad: 0};
        geo_tab[3] = '{pos: 35, tap: 8, exp_addr: 54, exp_pad: 0};
        geo_tab[4] = '{pos: 5,  tap: 2, exp_addr: 0,  exp_pad: 1};
        geo_tab[5] = '{pos: 14, tap: 0, exp_addr: 9,  exp_pad: 0};
        geo_tab[6] = '{pos: 6,  tap: 3, exp_addr: 0,  exp_pad: 1};
        geo_tab[7] = '{pos: 30, tap: 7, exp_addr: 48, exp_pad: 0};
        for (int p = 0; p < 36; p++)
            for (int t = 0; t < 9; t++) begin
                obs_addr[p][t] = -1;
                obs_pad[p][t]  = -1;
            end

        rst_n = 1'b0;
        ena = 1'b1;
        pix_valid = 1'b1;
        pipe_valid = 1'b0;
        restart = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_buf_we", int'(buf_we), 0);
        chk("rst_acc_en", int'(acc_en), 0);
        chk("rst_commit", int'(commit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_buf_waddr", int'(buf_waddr), 0);
        chk("rst_tap_pad", int'(tap_pad), 0);
        tick();
        rst_n = 1'b1;

        // Run 1: full load, CONV with a 5-cycle stall at pos 12 tap 4
        fill_conv_q();
        mon_en = 1'b1;
        load_image();

        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            sample();
            if (pos_idx == 6'd12 && tap_idx == 4'd3 && acc_en) found = 1'b1;
            tick();
            if (found) break;
        end
        chk("stall_reach_timeout", int'(found), 1);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("stall_acc_en", int'(acc_en), 0);
            chk("stall_acc_clr", int'(acc_clr), 0);
            chk("stall_commit", int'(commit), 0);
            chk("stall_pos", int'(pos_idx), 12);
            chk("stall_tap", int'(tap_idx), 4);
            tick();
        end
        ena = 1'b1;

        wait_conv_done();
        send_results(36);
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            if (done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("run1_done", int'(found), 1);
        chk("run1_err", int'(err), 0);
        chk("run1_busy", int'(busy), 0);
        tick();

        // Tap geometry table
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("geo_addr_p%0d_t%0d", geo_tab[i].pos, geo_tab[i].tap),
                obs_addr[geo_tab[i].pos][geo_tab[i].tap], geo_tab[i].exp_addr);
            chk($sformatf("geo_pad_p%0d_t%0d", geo_tab[i].pos, geo_tab[i].tap),
                obs_pad[geo_tab[i].pos][geo_tab[i].tap], geo_tab[i].exp_pad);
        end

        // Overcount in DONE
        pipe_valid = 1'b1;
        tick();
        pipe_valid = 1'b0;
        sample();
        chk("overcount_err", int'(err), 1);
        chk("overcount_done", int'(done), 1);
        tick();
        do_restart();

        // Run 2: only 35 results -> drain timeout
        fill_conv_q();
        load_image();
        wait_conv_done();
        send_results(34);
        pipe_valid = 1'b1;
        tick();
        pipe_valid = 1'b0;
        idle_n = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done) begin
                idle_n = n;
                break;
            end
        end
        chk("drain_timeout_cycles", idle_n, 15);
        chk("timeout_err", int'(err), 1);
        chk("timeout_done", int'(done), 1);
        do_restart();

        // Run 3: reset mid-CONV at pos 20
        fill_conv_q();
        load_image();
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            sample();
            if (pos_idx == 6'd20) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("pos20_timeout", int'(found), 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_acc_en", int'(acc_en), 0);
        chk("midrst_commit", int'(commit), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pix_ready", int'(pix_ready), 0);
        chk("midrst_pos", int'(pos_idx), 0);
        chk("midrst_tap_addr", int'(tap_addr), 0);
        chk("midrst_err", int'(err), 0);
        conv_q.delete();
        tick();
        rst_n = 1'b1;
        sample();
        chk("postrst_pix_ready", int'(pix_ready), 1);
        chk("postrst_waddr", int'(buf_waddr), 0);
        chk("postrst_busy", int'(busy), 0);
        chk("postrst_done", int'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
